// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the instruction/data bus arbiter.
package mips_bus_pkg;

    // Arbiter FSM: idle, strobe on the bus, wait for read data
    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } arb_state_t;

    // Which CPU port owns the current (or most recent) bus transaction
    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    // Instruction fetches always read a full 32-bit word
    localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Two-way round-robin picker between the fetch port and the load/store port.
module mips_bus_rr_pick
    import mips_bus_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_owner
);

    // A lone requester wins; on a tie the port that was not granted last wins
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (i_req && d_req) begin
            grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory bus between the fetch port and the
// load/store port, one transaction at a time, with registered bus outputs.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_ack,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW/8-1:0]   d_be,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_ack,
    output logic [DW-1:0]     d_rdata,
    output logic [AW-1:0]     address,
    output logic              read,
    output logic              write,
    output logic [DW/8-1:0]   byteenable,
    output logic [DW-1:0]     writedata,
    input  logic [DW-1:0]     readdata,
    input  logic              waitrequest
);

    localparam int BW = DW / 8;

    arb_state_t      state;
    arb_state_t      state_nxt;
    owner_t          owner;
    owner_t          owner_nxt;
    owner_t          last_grant;
    owner_t          last_grant_nxt;
    logic            grant_valid;
    owner_t          grant_owner;

    logic [AW-1:0]   address_nxt;
    logic            read_nxt;
    logic            write_nxt;
    logic [BW-1:0]   byteenable_nxt;
    logic [DW-1:0]   writedata_nxt;
    logic            i_ack_nxt;
    logic            d_ack_nxt;
    logic [DW-1:0]   i_rdata_nxt;
    logic [DW-1:0]   d_rdata_nxt;

    mips_bus_rr_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant from IDLE, leave BUS once the strobe is accepted
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_valid) state_nxt = BUS;
            BUS:  if (!waitrequest) state_nxt = write ? IDLE : RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the bus, ack and read-data registers for each state
    always_comb begin
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        address_nxt    = address;
        read_nxt       = read;
        write_nxt      = write;
        byteenable_nxt = byteenable;
        writedata_nxt  = writedata;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        i_rdata_nxt    = i_rdata;
        d_rdata_nxt    = d_rdata;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    owner_nxt      = grant_owner;
                    last_grant_nxt = grant_owner;
                    if (grant_owner == OWN_I) begin
                        address_nxt    = i_addr;
                        read_nxt       = 1'b1;
                        write_nxt      = 1'b0;
                        byteenable_nxt = {(BW/4){FETCH_BE}};
                    end else begin
                        address_nxt    = d_addr;
                        read_nxt       = ~d_we;
                        write_nxt      = d_we;
                        byteenable_nxt = d_be;
                        writedata_nxt  = d_wdata;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    if (write) begin
                        i_ack_nxt = (owner == OWN_I);
                        d_ack_nxt = (owner == OWN_D);
                    end
                end
            end
            RESP: begin
                if (owner == OWN_I) begin
                    i_rdata_nxt = readdata;
                    i_ack_nxt   = 1'b1;
                end else begin
                    d_rdata_nxt = readdata;
                    d_ack_nxt   = 1'b1;
                end
            end
            default: begin
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset drops strobes at once with no ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_I;
            last_grant <= OWN_I;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            address    <= address_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            byteenable <= byteenable_nxt;
            writedata  <= writedata_nxt;
            i_ack      <= i_ack_nxt;
            d_ack      <= d_ack_nxt;
            i_rdata    <= i_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
        end
    end

endmodule
